// File: rtl/carrega_instrucoes.sv
// Instruction-memory loader: assembles a little-endian byte stream into
// 32-bit words and writes them to consecutive word indices 0..N-1 while
// holding the CPU halted.
module carrega_instrucoes #(
  parameter int DEPTH  = 11,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inicio,
  input  logic [ADDR_W-1:0] n_palavras,
  input  logic              aborta,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ready,
  output logic              ocupado,
  output logic              cpu_halt,
  output logic              concluido,
  output logic              erro
);

  typedef enum logic [1:0] {
    OCIOSO,
    RECEBE,
    GRAVA,
    FIM
  } estado_t;

  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

  estado_t           estado;
  estado_t           prox;
  logic [ADDR_W-1:0] n_lat;
  logic [ADDR_W-1:0] word_cnt;
  logic [1:0]        byte_cnt;
  logic [31:0]       palavra;
  logic              erro_r;
  logic              aborto;
  logic              ultima;

  // An abort only means something once a load has started.
  assign aborto = aborta && (estado != OCIOSO);
  // The word being written is the last one of the load.
  assign ultima = (word_cnt + ADDR_W'(1)) == n_lat;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) estado <= OCIOSO;
    else        estado <= prox;
  end

  // Next-state decode and Moore-style outputs; abort overrides every transition.
  always_comb begin
    prox       = estado;
    byte_ready = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    concluido  = 1'b0;
    case (estado)
      OCIOSO: begin
        if (inicio) begin
          if (n_palavras > DEPTH_A)  prox = OCIOSO;
          else if (n_palavras == '0) prox = FIM;
          else                       prox = RECEBE;
        end
      end
      RECEBE: begin
        byte_ready = 1'b1;
        if (byte_valid && (byte_cnt == 2'd3)) prox = GRAVA;
      end
      GRAVA: begin
        mem_we    = 1'b1;
        mem_addr  = word_cnt;
        mem_wdata = palavra;
        if (mem_ready) prox = ultima ? FIM : RECEBE;
      end
      FIM: begin
        concluido = !aborta;
        prox      = OCIOSO;
      end
      default: prox = OCIOSO;
    endcase
    if (aborto) prox = OCIOSO;
  end

  assign ocupado  = (estado != OCIOSO);
  assign cpu_halt = ocupado;
  assign erro     = erro_r;

  // Counters, latched word count, byte assembly and the registered error pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_lat    <= '0;
      word_cnt <= '0;
      byte_cnt <= '0;
      palavra  <= '0;
      erro_r   <= 1'b0;
    end else begin
      erro_r <= 1'b0;
      if (aborto) begin
        // Partial word is thrown away; words already written stay in memory.
        erro_r   <= 1'b1;
        byte_cnt <= '0;
        palavra  <= '0;
      end else begin
        case (estado)
          OCIOSO: begin
            if (inicio) begin
              if (n_palavras > DEPTH_A) begin
                erro_r <= 1'b1;
              end else begin
                n_lat    <= n_palavras;
                word_cnt <= '0;
                byte_cnt <= '0;
                palavra  <= '0;
              end
            end
          end
          RECEBE: begin
            if (byte_valid) begin
              palavra[{byte_cnt, 3'b000} +: 8] <= byte_in;
              byte_cnt <= byte_cnt + 2'd1;
            end
          end
          GRAVA: begin
            if (mem_ready) word_cnt <= word_cnt + ADDR_W'(1);
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_carrega_instrucoes.sv
// Scoreboard bench for carrega_instrucoes: the driver predicts the writes and
// completion events of each load; a negedge monitor checks what the DUT emits.
module tb_carrega_instrucoes;

  localparam int DEPTH  = 11;
  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              inicio = 1'b0;
  logic [ADDR_W-1:0] n_palavras = '0;
  logic              aborta = 1'b0;
  logic [7:0]        byte_in = '0;
  logic              byte_valid = 1'b0;
  logic              byte_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_ready = 1'b1;
  logic              ocupado;
  logic              cpu_halt;
  logic              concluido;
  logic              erro;

  carrega_instrucoes #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .inicio(inicio), .n_palavras(n_palavras),
    .aborta(aborta), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .ocupado(ocupado),
    .cpu_halt(cpu_halt), .concluido(concluido), .erro(erro)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int rst_cnt = 0;
  always @(negedge rst_n) rst_cnt = rst_cnt + 1;

  typedef struct {
    int          kind;   // 0 write, 1 concluido, 2 erro
    int          addr;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  logic [7:0]  byte_q[$];
  logic [31:0] ref_mem[DEPTH];
  logic [31:0] img_mem[DEPTH];
  int          compared = 0;
  int          mismatched = 0;
  int          stall_cnt = 0;
  bit          mr_rand = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // memory-ready pattern: directed stall count first, else random or always ready
  initial begin
    forever begin
      @(posedge clk); #1;
      if (stall_cnt > 0) begin
        mem_ready = 1'b0;
        stall_cnt--;
      end else begin
        mem_ready = mr_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
      end
    end
  end

  // monitor: pops expectations whenever the DUT shows a write or an event
  logic              pst = 1'b0;
  logic              pab = 1'b0;
  logic [ADDR_W-1:0] pa;
  logic [31:0]       pd;
  int                prst = 0;
  initial begin
    exp_t e;
    for (int i = 0; i < DEPTH; i++) img_mem[i] = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pst = 1'b0;
        continue;
      end
      check("halt_eq_ocupado", 32'(cpu_halt), 32'(ocupado));
      if (pst && !pab && (prst == rst_cnt)) begin
        check("stall_we", 32'(mem_we), 32'd1);
        check("stall_addr", 32'(mem_addr), 32'(pa));
        check("stall_data", mem_wdata, pd);
      end
      if (mem_we) check("addr_range", 32'(mem_addr < ADDR_W'(DEPTH)), 32'd1);
      if (mem_we && mem_ready) begin
        check("write_expected", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check("write_kind", 32'(e.kind), 32'd0);
          check("write_addr", 32'(mem_addr), 32'(e.addr));
          check("write_data", mem_wdata, e.data);
        end
        if (mem_addr < ADDR_W'(DEPTH)) img_mem[mem_addr] = mem_wdata;
      end
      if (concluido) begin
        check("conc_expected", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check("conc_kind", 32'(e.kind), 32'd1);
        end
      end
      if (erro) begin
        check("erro_expected", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check("erro_kind", 32'(e.kind), 32'd2);
        end
      end
      pst  = mem_we && !mem_ready;
      pa   = mem_addr;
      pd   = mem_wdata;
      pab  = aborta;
      prst = rst_cnt;
    end
  end

  // reference model: a load of n words (mode 0), aborted after abort_at bytes
  // (mode 1) or cut by reset before any write completes (mode 2)
  task automatic expect_load(input int n, input int mode, input int abort_at);
    int words;
    int v;
    if (n > DEPTH) begin
      sb.push_back('{kind: 2, addr: 0, data: 32'd0});
      return;
    end
    if (n == 0) begin
      sb.push_back('{kind: 1, addr: 0, data: 32'd0});
      return;
    end
    words = (mode == 0) ? n : (mode == 1) ? abort_at / 4 : 0;
    for (int w = 0; w < words; w++) begin
      v = int'(byte_q[4*w]) + 256 * int'(byte_q[4*w+1]) +
          65536 * int'(byte_q[4*w+2]) + 16777216 * int'(byte_q[4*w+3]);
      sb.push_back('{kind: 0, addr: w, data: 32'(v)});
      ref_mem[w] = 32'(v);
    end
    if (mode == 0) sb.push_back('{kind: 1, addr: 0, data: 32'd0});
    if (mode == 1) sb.push_back('{kind: 2, addr: 0, data: 32'd0});
  endtask

  task automatic fill_random(input int n);
    byte_q.delete();
    for (int i = 0; i < 4 * n; i++) byte_q.push_back(8'($urandom));
  endtask

  // driver for one load; byte_q must hold the stream beforehand
  task automatic run_load(input int n, input bit gaps, input int mode, input int abort_at,
                          input int stall_w0, input bit chk_lat);
    int  c0;
    int  idx;
    int  guard;
    int  stop;
    bit  halt_ok;
    expect_load(n, mode, abort_at);
    @(posedge clk); #1;
    inicio     = 1'b1;
    n_palavras = ADDR_W'(n);
    c0         = cyc;
    @(posedge clk); #1;
    inicio     = 1'b0;
    n_palavras = ADDR_W'($urandom);
    if (n > DEPTH) begin
      @(negedge clk);
      check("reject_ocupado", 32'(ocupado), 32'd0);
      @(posedge clk); #1;
      return;
    end
    if (n == 0) begin
      @(negedge clk);
      check("zero_conc_latency", 32'(concluido), 32'd1);
      @(posedge clk); #1;
      return;
    end
    halt_ok = 1'b1;
    stop    = (mode == 1) ? abort_at : (mode == 2) ? 4 : 4 * n;
    idx     = 0;
    guard   = 0;
    while (idx < stop && guard < 3000) begin
      byte_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      byte_in    = byte_valid ? byte_q[idx] : 8'($urandom);
      @(negedge clk);
      if (!cpu_halt) halt_ok = 1'b0;
      if (byte_valid && byte_ready) begin
        idx++;
        if (idx == 4 && stall_w0 > 0) stall_cnt = stall_w0;
      end
      @(posedge clk); #1;
      guard++;
    end
    byte_valid = 1'b0;
    check("feed_complete", 32'(idx), 32'(stop));
    if (mode == 1) begin
      aborta = 1'b1;
      @(posedge clk); #1;
      aborta = 1'b0;
      @(negedge clk);
      check("abort_idle", 32'(ocupado), 32'd0);
      check("abort_no_we", 32'(mem_we), 32'd0);
      @(posedge clk); #1;
      return;
    end
    if (mode == 2) begin
      @(negedge clk);
      check("in_grava_before_reset", 32'(mem_we), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("rst_we", 32'(mem_we), 32'd0);
      check("rst_ocupado", 32'(ocupado), 32'd0);
      check("rst_byte_ready", 32'(byte_ready), 32'd0);
      check("rst_halt", 32'(cpu_halt), 32'd0);
      stall_cnt = 0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_idle", 32'(ocupado), 32'd0);
      @(posedge clk); #1;
      return;
    end
    guard = 0;
    forever begin
      @(negedge clk);
      if (concluido || guard >= 800) break;
      if (!cpu_halt) halt_ok = 1'b0;
      guard++;
    end
    check("done_seen", 32'(concluido), 32'd1);
    check("halt_during_load", 32'(halt_ok), 32'd1);
    if (chk_lat) check("conc_cycle", 32'(cyc - c0), 32'(5 * n + 1));
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", compared);
    $fatal(1);
  end

  initial begin
    int n;
    int ab;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_state_ocupado", 32'(ocupado), 32'd0);
    check("rst_state_halt", 32'(cpu_halt), 32'd0);
    check("rst_state_ready", 32'(byte_ready), 32'd0);
    check("rst_state_we", 32'(mem_we), 32'd0);
    check("rst_state_addr", 32'(mem_addr), 32'd0);
    check("rst_state_wdata", mem_wdata, 32'd0);
    check("rst_state_conc", 32'(concluido), 32'd0);
    check("rst_state_erro", 32'(erro), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // two-word program, continuous stream
    byte_q = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    run_load(2, 1'b0, 0, 0, 0, 1'b1);
    check("case1_mem0", img_mem[0], 32'h0000_0013);
    check("case1_mem1", img_mem[1], 32'h0010_0093);

    // same program with byte gaps and a 3-cycle memory stall on word 0
    for (int i = 0; i < DEPTH; i++) begin
      img_mem[i] = '0;
      ref_mem[i] = '0;
    end
    byte_q = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    run_load(2, 1'b1, 0, 0, 3, 1'b0);
    check("case2_mem0", img_mem[0], 32'h0000_0013);
    check("case2_mem1", img_mem[1], 32'h0010_0093);

    // rejected start and empty load
    run_load(12, 1'b0, 0, 0, 0, 1'b0);
    run_load(0, 1'b0, 0, 0, 0, 1'b0);

    // full depth
    fill_random(DEPTH);
    run_load(DEPTH, 1'b0, 0, 0, 0, 1'b1);

    // abort after two bytes of word 1, then a normal load
    fill_random(2);
    run_load(2, 1'b0, 1, 6, 0, 1'b0);
    fill_random(3);
    run_load(3, 1'b1, 0, 0, 0, 1'b0);

    // asynchronous reset while stalled in the write state
    fill_random(2);
    run_load(2, 1'b0, 2, 0, 50, 1'b0);

    // randomized loads with random gaps, memory stalls and aborts
    mr_rand = 1'b1;
    for (int t = 0; t < 12; t++) begin
      n = $urandom_range(0, 14);
      fill_random((n <= DEPTH) ? n : 0);
      if (n >= 1 && n <= DEPTH && $urandom_range(0, 3) == 0) begin
        ab = 4 * $urandom_range(0, n - 1) + $urandom_range(1, 3);
        run_load(n, 1'($urandom_range(0, 1)), 1, ab, 0, 1'b0);
      end else begin
        run_load(n, 1'($urandom_range(0, 1)), 0, 0, 0, 1'b0);
      end
    end
    mr_rand = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);

    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    for (int i = 0; i < DEPTH; i++) check("mem_image", img_mem[i], ref_mem[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
